uart_rx_axis_fifo: RTL and testbench

UART_RX_AXIS_FIFO -- requirements
Module: uart_rx_axis_fifo

---
 rtl/uart_rx_axis_fifo.sv | 123 ++++++++++++
 tb/tb_uart_rx_axis_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axis_fifo.sv
// UART word strobe to AXI-Stream FWFT FIFO with a tlast every PKT_LEN beats; optional drop counter under RX_FIFO_DROP_CNT_EN.
// Latency: word written at edge N is valid in cycle N+1; a full FIFO drops input (sticky overflow), m_tready stalls output.
module uart_rx_axis_fifo #(
    parameter int W_DATA  = 24,
    parameter int DEPTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_valid,
    input  logic [W_DATA-1:0]        s_data,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [W_DATA-1:0]        m_tdata,
    output logic                     m_tlast,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [15:0]              drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(PKT_LEN) + 1;

    logic [W_DATA-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              ovf_q, ovf_d;
    logic              full, rd_fire, wr_en, drop;

    assign full     = (level_q == LW'(DEPTH));
    assign m_tvalid = (level_q != '0);
    assign rd_fire  = m_tvalid & m_tready;
    // A full FIFO still accepts when the same cycle frees a slot.
    assign wr_en    = s_valid & (~full | rd_fire);
    assign drop     = s_valid & full & ~rd_fire;

    assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;
    assign m_tlast  = m_tvalid & (beat_q == BW'(PKT_LEN - 1));
    assign level    = level_q;
    assign overflow = ovf_q;

    always_comb begin
        level_d = level_q;
        case ({wr_en, rd_fire})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        beat_d = beat_q;
        if (rd_fire) begin
            beat_d = (beat_q == BW'(PKT_LEN - 1)) ? '0 : beat_q + 1'b1;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            beat_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            beat_q  <= beat_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef RX_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A clear coinciding with a drop leaves exactly that one drop counted.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && ovf_clr) begin
            drop_cnt_d = 16'd1;
        end else if (ovf_clr) begin
            drop_cnt_d = 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Bench for uart_rx_axis_fifo: directed scenarios plus random traffic against a queue-based reference.
module tb_uart_rx_axis_fifo;
    localparam int W       = 24;
    localparam int DEPTH   = 8;
    localparam int PKT_LEN = 4;
    localparam int LW      = $clog2(DEPTH) + 1;

`ifdef RX_FIFO_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_valid = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [W-1:0]  m_tdata;
    logic          m_tlast;
    logic [LW-1:0] level;
    logic          overflow;
    logic          ovf_clr = 1'b0;
    logic [15:0]   drop_count;

    uart_rx_axis_fifo #(.W_DATA(W), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .level(level), .overflow(overflow), .ovf_clr(ovf_clr), .drop_count(drop_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_lvl = 0;
    int   acc_idx = 0;
    bit   exp_ovf = 1'b0;
    int   exp_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake pops the oldest expected beat.
    always @(negedge clk) begin
        exp_t e;
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got data %0h, expected no beat at %0t", m_tdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 32'(m_tdata), 32'(e.d));
                check("beat_last", 32'(m_tlast), 32'(e.l));
            end
        end
    end

    task automatic check_state();
        check("level", 32'(level), exp_lvl);
        check("tvalid", 32'(m_tvalid), 32'(exp_lvl != 0));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("drop_count", 32'(drop_count), exp_drop);
        if (exp_lvl == 0) begin
            check("empty_tdata", 32'(m_tdata), 32'd0);
            check("empty_tlast", 32'(m_tlast), 32'd0);
        end
    endtask

    // Called at posedge+1: drives one cycle, updates the reference, checks after the edge.
    task automatic step(input logic sv, input logic [W-1:0] sd, input logic rdy, input logic clr);
        bit rd, acc, drop;
        s_valid  = sv;
        s_data   = sd;
        m_tready = rdy;
        ovf_clr  = clr;
        rd   = rdy && (exp_lvl > 0);
        acc  = sv && ((exp_lvl < DEPTH) || rd);
        drop = sv && !acc;
        if (acc) begin
            exp_q.push_back(exp_t'{d: sd, l: ((acc_idx % PKT_LEN) == PKT_LEN - 1)});
            acc_idx++;
        end
        exp_lvl = exp_lvl + int'(acc) - int'(rd);
        if (drop) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
        if (CNT_EN) begin
            if (drop && clr) exp_drop = 1;
            else if (clr) exp_drop = 0;
            else if (drop && exp_drop < 65535) exp_drop++;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        s_valid  = 1'b0;
        s_data   = '0;
        m_tready = 1'b0;
        ovf_clr  = 1'b0;
        rstn     = 1'b0;
        exp_q.delete();
        exp_lvl  = 0;
        acc_idx  = 0;
        exp_ovf  = 1'b0;
        exp_drop = 0;
        #2;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) step(1'b1, W'(base + i), 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Single word, immediate read.
        do_reset();
        step(1'b1, 24'hA1B2C3, 1'b1, 1'b0);
        check("s1_tvalid", 32'(m_tvalid), 32'd1);
        check("s1_tdata", 32'(m_tdata), 32'hA1B2C3);
        check("s1_tlast", 32'(m_tlast), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("s1_level_after", 32'(level), 32'd0);

        // Fill, drop the ninth, drain in order with tlast on 4 and 8.
        do_reset();
        fill(8, 1);
        check("s2_level_full", 32'(level), 32'd8);
        step(1'b1, W'(9), 1'b0, 1'b0);
        check("s2_overflow", 32'(overflow), 32'd1);
        check("s2_drop_count", 32'(drop_count), CNT_EN ? 32'd1 : 32'd0);
        drain(8);

        // Full with simultaneous read and write, then drop with clear.
        do_reset();
        fill(8, 1);
        step(1'b1, W'(10), 1'b1, 1'b0);
        check("s3_level", 32'(level), 32'd8);
        check("s3_overflow", 32'(overflow), 32'd0);
        step(1'b1, W'(11), 1'b0, 1'b1);
        check("s4_overflow", 32'(overflow), 32'd1);
        check("s4_drop_count", 32'(drop_count), CNT_EN ? 32'd1 : 32'd0);
        step(1'b0, '0, 1'b0, 1'b1);
        drain(8);

        // Backpressure hold.
        do_reset();
        step(1'b1, 24'h00FF00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            check("s5_hold_tdata", 32'(m_tdata), 32'h00FF00);
            check("s5_hold_tlast", 32'(m_tlast), 32'd0);
            check("s5_hold_level", 32'(level), 32'd1);
        end
        drain(1);

        // Reset mid-packet, next packet restarts at beat 0.
        do_reset();
        fill(8, 32'h100);
        drain(2);
        do_reset();
        fill(4, 32'h200);
        drain(4);

        // Random traffic with varying read pressure.
        do_reset();
        for (int ph = 0; ph < 5; ph++) begin
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(0, 499) == 0) begin
                    do_reset();
                end else begin
                    step(1'($urandom_range(0, 1)), W'($urandom),
                         ($urandom_range(0, 3) < ph), ($urandom_range(0, 15) == 0));
                end
            end
        end
        drain(DEPTH + 2);
        check("final_scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
